// File: rtl/sap_ram_ctrl_if.sv
// Control and handshake signals for the SAP RAM controller; the shared data
// bus stays a plain inout on the controller so tristate resolution stays at net level.
interface sap_ram_ctrl_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    logic              enable;
    logic              we;
    logic [ADDR_W-1:0] address;
    logic              prog_mode;
    logic              prog_strobe;
    logic [DATA_W-1:0] prog_data_in;
    logic [ADDR_W-1:0] prog_addr;
    logic              prog_wrap;
    logic              busy;
    logic              rd_valid;

    modport master (
        output enable, we, address, prog_mode, prog_strobe, prog_data_in,
        input  prog_addr, prog_wrap, busy, rd_valid
    );

    modport slave (
        input  enable, we, address, prog_mode, prog_strobe, prog_data_in,
        output prog_addr, prog_wrap, busy, rd_valid
    );
endinterface

// File: rtl/sap_ram_ctrl.sv
// SAP RAM: registered-read synchronous memory on a tristate bus, with an
// optional post-reset clear sweep and an auto-incrementing program loader.
module sap_ram_ctrl #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sap_ram_ctrl_if.slave          bus,
    inout  wire  [DATA_W-1:0]      data
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_PROG
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
    logic              rd_valid_q, rd_valid_d;
    logic              prog_wrap_q, prog_wrap_d;
    logic [DATA_W-1:0] out_reg;
    logic              rd_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            clr_ptr_q   <= '0;
            prog_addr_q <= '0;
            rd_valid_q  <= 1'b0;
            prog_wrap_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            prog_addr_q <= prog_addr_d;
            rd_valid_q  <= rd_valid_d;
            prog_wrap_q <= prog_wrap_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        prog_addr_d = prog_addr_q;
        rd_valid_d  = 1'b0;
        prog_wrap_d = 1'b0;
        rd_en       = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = bus.address;
        mem_wdata   = data;
        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (clr_ptr_q == '1) state_d = S_IDLE;
            end
            S_IDLE: begin
                // Entering PROG takes priority; a bus request in the same cycle is dropped.
                if (bus.prog_mode) begin
                    state_d     = S_PROG;
                    prog_addr_d = '0;
                end else if (bus.enable) begin
                    if (bus.we) begin
                        mem_we = 1'b1;
                    end else begin
                        rd_en      = 1'b1;
                        rd_valid_d = 1'b1;
                    end
                end
            end
            S_PROG: begin
                if (bus.prog_strobe) begin
                    mem_we      = 1'b1;
                    mem_waddr   = prog_addr_q;
                    mem_wdata   = bus.prog_data_in;
                    prog_addr_d = prog_addr_q + ADDR_W'(1);
                    prog_wrap_d = (prog_addr_q == '1);
                end
                if (!bus.prog_mode) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory has no reset; writes are suppressed while rst_n is low.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)     out_reg <= '0;
        else if (rd_en) out_reg <= mem[bus.address];
    end

    assign data = (bus.enable && !bus.we && state_q == S_IDLE) ? out_reg : 'z;

    assign bus.busy      = (state_q == S_CLEAR);
    assign bus.rd_valid  = rd_valid_q;
    assign bus.prog_addr = prog_addr_q;
    assign bus.prog_wrap = prog_wrap_q;
endmodule

// File: tb/tb_sap_ram_ctrl.sv
// Directed bench for sap_ram_ctrl: clear sweep, bus read/write, program load,
// PROG isolation, reset mid-operation, and the no-clear variant.
module tb_sap_ram_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Pulled-up bus: an undriven bus reads 8'hFF, which stands for hi-Z.
    tri1 [7:0] data_a;
    tri1 [7:0] data_b;
    logic       drv_a, drv_b;
    logic [7:0] val_a, val_b;
    assign data_a = drv_a ? val_a : 'z;
    assign data_b = drv_b ? val_b : 'z;

    sap_ram_ctrl_if #(.DATA_W(8), .ADDR_W(4)) ifa ();
    sap_ram_ctrl_if #(.DATA_W(8), .ADDR_W(4)) ifb ();

    sap_ram_ctrl #(.DATA_W(8), .ADDR_W(4), .CLEAR_ON_RESET(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa), .data(data_a)
    );
    sap_ram_ctrl #(.DATA_W(8), .ADDR_W(4), .CLEAR_ON_RESET(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb), .data(data_b)
    );

    int checks   = 0;
    int failures = 0;
    logic busy_b_seen = 1'b0;

    always @(negedge clk) if (ifb.busy === 1'b1) busy_b_seen = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (ifa.busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    int n;

    initial begin
        rst_n = 1'b0;
        drv_a = 1'b0; val_a = '0; drv_b = 1'b0; val_b = '0;
        ifa.enable = 0; ifa.we = 0; ifa.address = '0;
        ifa.prog_mode = 0; ifa.prog_strobe = 0; ifa.prog_data_in = '0;
        ifb.enable = 0; ifb.we = 0; ifb.address = '0;
        ifb.prog_mode = 0; ifb.prog_strobe = 0; ifb.prog_data_in = '0;

        // Reset state
        tick(); tick();
        check_eq("rst_busy",      ifa.busy, 1);
        check_eq("rst_rd_valid",  ifa.rd_valid, 0);
        check_eq("rst_prog_addr", ifa.prog_addr, 0);
        check_eq("rst_prog_wrap", ifa.prog_wrap, 0);
        check_eq("rst_data_hiz",  data_a, 8'hFF);
        check_eq("rst_b_busy",    ifb.busy, 0);

        // T1: sweep length, then every word reads zero
        rst_n = 1'b1;
        count_busy(n);
        check_eq("t1_busy_len", n, 16);
        ifa.enable = 1; ifa.we = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            ifa.address = 4'(i);
            tick();
            check_eq($sformatf("t1_rv_%0d", i), ifa.rd_valid, 1);
            check_eq($sformatf("t1_rd_%0d", i), data_a, 8'h00);
        end
        ifa.enable = 0;
        tick();
        check_eq("t1_idle_hiz", data_a, 8'hFF);
        check_eq("t1_idle_rv",  ifa.rd_valid, 0);

        // T2: write A5 @3, read it back next cycle
        ifa.enable = 1; ifa.we = 1; ifa.address = 4'd3;
        drv_a = 1; val_a = 8'hA5;
        tick();
        check_eq("t2_wr_bus", data_a, 8'hA5);
        check_eq("t2_wr_rv",  ifa.rd_valid, 0);
        drv_a = 0;
        ifa.address = 4'd4;
        tick();
        check_eq("t2_wr_hiz", data_a, 8'hFF);
        ifa.we = 0; ifa.address = 4'd3;
        tick();
        check_eq("t2_rd_rv",   ifa.rd_valid, 1);
        check_eq("t2_rd_data", data_a, 8'hA5);
        ifa.address = 4'd4;
        tick();
        check_eq("t2_rd4_data", data_a, 8'hFF);
        ifa.we = 1; ifa.address = 4'd5; drv_a = 1; val_a = 8'h5C;
        tick();
        check_eq("t2_rv_after_wr", ifa.rd_valid, 0);
        drv_a = 0; ifa.enable = 0; ifa.we = 0;

        // T3: program load 10..1F
        ifa.prog_mode = 1;
        tick();
        check_eq("t3_enter_addr", ifa.prog_addr, 0);
        check_eq("t3_enter_hiz",  data_a, 8'hFF);
        for (int unsigned i = 0; i < 16; i++) begin
            ifa.prog_strobe = 1; ifa.prog_data_in = 8'(8'h10 + i);
            tick();
            check_eq($sformatf("t3_wrap_%0d", i), ifa.prog_wrap, (i == 15) ? 1 : 0);
            check_eq($sformatf("t3_addr_%0d", i), ifa.prog_addr, (i + 1) % 16);
        end
        ifa.prog_strobe = 0; ifa.prog_mode = 0;
        tick();
        check_eq("t3_wrap_once", ifa.prog_wrap, 0);
        check_eq("t3_addr_end",  ifa.prog_addr, 0);
        ifa.enable = 1; ifa.we = 0; ifa.address = 4'd7;
        tick();
        check_eq("t3_rd7_rv", ifa.rd_valid, 1);
        check_eq("t3_rd7",    data_a, 8'h17);
        ifa.address = 4'd15;
        tick();
        check_eq("t3_rd15", data_a, 8'h1F);
        ifa.address = 4'd0;
        tick();
        check_eq("t3_rd0", data_a, 8'h10);

        // T4: bus read while entering and sitting in PROG is ignored
        ifa.prog_mode = 1; ifa.address = 4'd7;
        tick();
        check_eq("t4_entry_rv",  ifa.rd_valid, 0);
        check_eq("t4_entry_hiz", data_a, 8'hFF);
        tick();
        check_eq("t4_prog_rv",  ifa.rd_valid, 0);
        check_eq("t4_prog_hiz", data_a, 8'hFF);
        ifa.enable = 0; ifa.prog_mode = 0;
        tick();

        // T5a: reset when clr_ptr reaches 5
        rst_n = 0;
        tick();
        rst_n = 1;
        repeat (5) tick();
        check_eq("t5_mid_busy", ifa.busy, 1);
        ifa.enable = 1; ifa.we = 0; ifa.prog_mode = 1;
        rst_n = 0;
        tick();
        rst_n = 1;
        check_eq("t5_clr_hiz", data_a, 8'hFF);
        check_eq("t5_clr_rv",  ifa.rd_valid, 0);
        ifa.enable = 0;
        count_busy(n);
        check_eq("t5a_busy_len", n, 16);
        ifa.prog_mode = 0;
        tick();

        // T5b: reset after three PROG strobes
        ifa.prog_mode = 1;
        tick();
        for (int unsigned i = 0; i < 3; i++) begin
            ifa.prog_strobe = 1; ifa.prog_data_in = 8'(8'hE0 + i);
            tick();
        end
        check_eq("t5_prog_addr3", ifa.prog_addr, 3);
        ifa.prog_data_in = 8'hEE;
        rst_n = 0;
        tick();
        check_eq("t5_rst_addr", ifa.prog_addr, 0);
        check_eq("t5_rst_busy", ifa.busy, 1);
        rst_n = 1; ifa.prog_strobe = 0; ifa.prog_mode = 0;
        count_busy(n);
        check_eq("t5b_busy_len", n, 16);
        ifa.enable = 1; ifa.we = 0; ifa.address = 4'd0;
        tick();
        check_eq("t5_rd0_cleared", data_a, 8'h00);
        ifa.address = 4'd3;
        tick();
        check_eq("t5_rd3_cleared", data_a, 8'h00);
        ifa.enable = 0;

        // T6: no-clear variant keeps contents across reset
        ifb.enable = 1; ifb.we = 1; ifb.address = 4'd9;
        drv_b = 1; val_b = 8'h3C;
        tick();
        drv_b = 0; ifb.enable = 0; ifb.we = 0;
        rst_n = 0;
        tick();
        rst_n = 1;
        check_eq("t6_rst_busy", ifb.busy, 0);
        ifb.enable = 1; ifb.address = 4'd9;
        tick();
        check_eq("t6_rd_rv", ifb.rd_valid, 1);
        check_eq("t6_rd9",   data_b, 8'h3C);
        ifb.enable = 0;
        repeat (20) tick();
        check_eq("t6_busy_never", busy_b_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
